clk_enable_network: RTL and testbench



---
 rtl/clk_enable_network.sv | 157 +++++++++++++++
 tb/tb_clk_enable_network.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_network.sv
// ---------------------------------------------------------------------------
// clk_enable_network
//
// Multi-channel clock-enable generator running entirely in the clk domain.
// Each channel divides one of four tick sources by a programmable ratio and
// emits a one-cycle enable pulse and an LED-style toggle at every wrap.
// Source selects come from raw switches. They are synchronised and debounced,
// then applied only at a channel's terminal count, so a channel never
// produces a shortened or doubled period while it switches.
//
// Ports:
//   clk            single system clock, rising edge
//   rst            synchronous active-high reset
//   sel_in         raw switch selects, channel i at [2i+1:2i]
//                  (0 every cycle, 1 div-2 strobe, 2 previous channel, 3 hold)
//   div_max_in     terminal count per channel, channel i at [i*CNT_W +: CNT_W]
//   ch_en_o        one-cycle enable pulse per channel wrap
//   ch_toggle_o    flips at every wrap
//   sel_active_o   select currently applied to each channel
//   sel_switched_o one-cycle pulse when a pending select is applied
// ---------------------------------------------------------------------------
module clk_enable_network #(
   parameter int         NUM_CH          = 3,
   parameter int         CNT_W           = 26,
   parameter int         DEBOUNCE_CYCLES = 50000,
   parameter logic [1:0] RESET_SEL       = 2'b00
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*NUM_CH-1:0]     sel_in,
   input  logic [NUM_CH*CNT_W-1:0] div_max_in,
   output logic [NUM_CH-1:0]       ch_en_o,
   output logic [NUM_CH-1:0]       ch_toggle_o,
   output logic [2*NUM_CH-1:0]     sel_active_o,
   output logic [NUM_CH-1:0]       sel_switched_o
);

   localparam int                  DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2*NUM_CH-1:0] SEL_RST = {NUM_CH{RESET_SEL}};

   typedef enum logic [1:0] {
      SRC_EVERY = 2'd0,
      SRC_DIV2  = 2'd1,
      SRC_CHAIN = 2'd2,
      SRC_HOLD  = 2'd3
   } src_e;

   logic [2*NUM_CH-1:0] sync1;
   logic [2*NUM_CH-1:0] sync2;
   logic [2*NUM_CH-1:0] sel_req;
   logic [DB_W-1:0]     db_cnt;
   logic                div2;

   // Switch input path shared by all channels. The bus is brought into the
   // clk domain with two flops, and any change of the synchronised value
   // restarts the debounce count. Once the value has sat still long enough
   // (db_cnt saturated and no new change arriving) it is copied into
   // sel_req. The div-2 phase register also lives here because every
   // channel in div-2 mode shares the same strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= SEL_RST;
         sync2   <= SEL_RST;
         sel_req <= SEL_RST;
         db_cnt  <= '0;
         div2    <= 1'b0;
      end else begin
         sync1 <= sel_in;
         sync2 <= sync1;
         div2  <= ~div2;
         if (sync1 != sync2) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            sel_req <= sync2;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             tick;
      logic             wrap;
      logic             apply;
      logic             chain_src;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] max_shadow;
      logic             en_q;
      logic             tog_q;
      logic             sw_q;
      src_e             act_q;
      src_e             req;

      // Channel 0 has no upstream channel, so chain mode behaves like
      // "every cycle" there.
      if (i == 0) begin : g_first
         assign chain_src = 1'b1;
      end else begin : g_next
         assign chain_src = ch_en_o[i-1];
      end

      assign req = src_e'(sel_req[2*i +: 2]);

      // Tick source selected by the applied select. Hold produces no ticks.
      always_comb begin
         tick = 1'b0;
         case (act_q)
            SRC_EVERY: tick = 1'b1;
            SRC_DIV2:  tick = div2;
            SRC_CHAIN: tick = chain_src;
            default:   tick = 1'b0;
         endcase
      end

      // A pending select is applied at the wrap so the current period always
      // completes. A held channel has no wraps to wait for, so it switches
      // on the next cycle instead and keeps its count.
      assign wrap  = tick && (cnt == max_shadow);
      assign apply = (req != act_q) && (wrap || (act_q == SRC_HOLD));

      // Divider counter, shadowed terminal count and registered outputs.
      // The terminal count is only sampled at reset, wrap or select apply,
      // so a new div_max_in mid-count never truncates the running period.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt        <= '0;
            max_shadow <= div_max_in[i*CNT_W +: CNT_W];
            en_q       <= 1'b0;
            tog_q      <= 1'b0;
            sw_q       <= 1'b0;
            act_q      <= src_e'(RESET_SEL);
         end else begin
            en_q <= wrap;
            sw_q <= apply;
            if (wrap) begin
               cnt   <= '0;
               tog_q <= ~tog_q;
            end else if (tick) begin
               cnt <= cnt + CNT_W'(1);
            end
            if (wrap || apply) begin
               max_shadow <= div_max_in[i*CNT_W +: CNT_W];
            end
            if (apply) begin
               act_q <= req;
            end
         end
      end

      assign ch_en_o[i]             = en_q;
      assign ch_toggle_o[i]         = tog_q;
      assign sel_switched_o[i]      = sw_q;
      assign sel_active_o[2*i +: 2] = act_q;
   end

endmodule

// File: tb/tb_clk_enable_network.sv
// ---------------------------------------------------------------------------
// tb_clk_enable_network
//
// Directed bench for clk_enable_network (3 channels, 8-bit counters,
// debounce of 4 cycles). A tick-level reference model of every channel is
// advanced on each rising edge. All outputs are compared against that model
// on each falling edge. Hand-worked periods, pulse counts and latencies
// pin the model to the intended behaviour.
// ---------------------------------------------------------------------------
module tb_clk_enable_network;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam int DB     = 4;

   localparam int K_EN  = 0;
   localparam int K_TOG = 1;
   localparam int K_SW  = 2;

   logic                    clk;
   logic                    rst;
   logic [2*NUM_CH-1:0]     sel_in;
   logic [NUM_CH*CNT_W-1:0] div_max_in;
   logic [NUM_CH-1:0]       ch_en_o;
   logic [NUM_CH-1:0]       ch_toggle_o;
   logic [2*NUM_CH-1:0]     sel_active_o;
   logic [NUM_CH-1:0]       sel_switched_o;

   int n_cmp;
   int n_bad;

   // Reference model state: per channel, ticks seen since the last wrap,
   // the ratio in force, the applied/requested sources and last outputs.
   bit         m_en   [NUM_CH];
   bit         m_tog  [NUM_CH];
   bit         m_sw   [NUM_CH];
   logic [1:0] m_act  [NUM_CH];
   logic [1:0] m_req  [NUM_CH];
   int         m_pos  [NUM_CH];
   int         m_lim  [NUM_CH];
   bit         m_half;
   logic [2*NUM_CH-1:0] m_hist[$];

   clk_enable_network #(
      .NUM_CH(NUM_CH),
      .CNT_W(CNT_W),
      .DEBOUNCE_CYCLES(DB),
      .RESET_SEL(2'b00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sel_in(sel_in),
      .div_max_in(div_max_in),
      .ch_en_o(ch_en_o),
      .ch_toggle_o(ch_toggle_o),
      .sel_active_o(sel_active_o),
      .sel_switched_o(sel_switched_o)
   );

   // Free-running 10 time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [2*NUM_CH-1:0] s, input logic [NUM_CH*CNT_W-1:0] m);
      rst        = r;
      sel_in     = s;
      div_max_in = m;
   endtask

   // One rising edge of the reference model. The select request takes the
   // switch value once the last DB+1 sampled values all agree (2 sync
   // stages plus DB stable cycles). A channel advances one position per
   // source tick and wraps after its ratio.
   task automatic modelEdge();
      bit prev_en [NUM_CH];
      bit tick;
      bit wrap;
      bit apply;
      bit same;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_en[i]  = 1'b0;
            m_tog[i] = 1'b0;
            m_sw[i]  = 1'b0;
            m_act[i] = 2'b00;
            m_req[i] = 2'b00;
            m_pos[i] = 0;
            m_lim[i] = int'(div_max_in[i*CNT_W +: CNT_W]);
         end
         m_half = 1'b0;
         m_hist.delete();
         for (int k = 0; k <= DB; k++) m_hist.push_back('0);
      end else begin
         prev_en = m_en;
         for (int i = 0; i < NUM_CH; i++) begin
            if (m_act[i] == 2'd0)      tick = 1'b1;
            else if (m_act[i] == 2'd1) tick = m_half;
            else if (m_act[i] == 2'd2) tick = (i == 0) ? 1'b1 : prev_en[i-1];
            else                       tick = 1'b0;
            wrap  = tick && (m_pos[i] == m_lim[i]);
            apply = (m_req[i] != m_act[i]) && (wrap || (m_act[i] == 2'd3));
            m_en[i] = wrap;
            m_sw[i] = apply;
            if (wrap) begin
               m_pos[i] = 0;
               m_tog[i] = !m_tog[i];
            end else if (tick) begin
               m_pos[i] = m_pos[i] + 1;
            end
            if (wrap || apply) m_lim[i] = int'(div_max_in[i*CNT_W +: CNT_W]);
            if (apply) m_act[i] = m_req[i];
         end
         m_half = !m_half;
         same = 1'b1;
         for (int k = 1; k < m_hist.size(); k++) if (m_hist[k] != m_hist[0]) same = 1'b0;
         if (same) for (int i = 0; i < NUM_CH; i++) m_req[i] = m_hist[0][2*i +: 2];
         m_hist.push_back(sel_in);
         void'(m_hist.pop_front());
      end
   endtask

   // Advance one cycle: model on the rising edge, compare on the falling one.
   task automatic step();
      logic [NUM_CH-1:0]   e_en;
      logic [NUM_CH-1:0]   e_tog;
      logic [NUM_CH-1:0]   e_sw;
      logic [2*NUM_CH-1:0] e_act;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
         e_en[i]         = m_en[i];
         e_tog[i]        = m_tog[i];
         e_sw[i]         = m_sw[i];
         e_act[2*i +: 2] = m_act[i];
      end
      checkOutput("model ch_en_o", 32'(ch_en_o), 32'(e_en));
      checkOutput("model ch_toggle_o", 32'(ch_toggle_o), 32'(e_tog));
      checkOutput("model sel_switched_o", 32'(sel_switched_o), 32'(e_sw));
      checkOutput("model sel_active_o", 32'(sel_active_o), 32'(e_act));
   endtask

   function automatic logic sigOf(input int kind, input int ch);
      if (kind == K_EN)  return ch_en_o[ch];
      if (kind == K_TOG) return ch_toggle_o[ch];
      return sel_switched_o[ch];
   endfunction

   // Cycles until the signal is seen high; -1 if the budget runs out.
   task automatic gapToPulse(input int kind, input int ch, input int budget, output int k);
      bit found;
      k     = -1;
      found = 1'b0;
      for (int c = 1; c <= budget && !found; c++) begin
         step();
         if (sigOf(kind, ch) === 1'b1) begin
            k     = c;
            found = 1'b1;
         end
      end
   endtask

   task automatic measurePeriod(input int kind, input int ch, input int budget, output int p);
      int first;
      gapToPulse(kind, ch, budget, first);
      if (first < 0) p = -1;
      else gapToPulse(kind, ch, budget, p);
   endtask

   // Pulses (or, for the toggle, level changes) seen over a window.
   task automatic countPulses(input int kind, input int ch, input int cycles, output int n);
      logic prev;
      n    = 0;
      prev = sigOf(kind, ch);
      for (int c = 0; c < cycles; c++) begin
         step();
         if (kind == K_TOG) begin
            if (sigOf(kind, ch) !== prev) n++;
         end else if (sigOf(kind, ch) === 1'b1) begin
            n++;
         end
         prev = sigOf(kind, ch);
      end
   endtask

   initial begin
      int n;
      int p;
      int nsw;
      logic tog0;

      n_cmp = 0;
      n_bad = 0;

      // Reset with every select 0 and ratios 1, 2, 5.
      applyStimulus(1'b1, 6'b00_00_00, {8'd4, 8'd1, 8'd0});
      repeat (3) step();
      checkOutput("reset ch_en_o", 32'(ch_en_o), 32'd0);
      checkOutput("reset ch_toggle_o", 32'(ch_toggle_o), 32'd0);
      checkOutput("reset sel_switched_o", 32'(sel_switched_o), 32'd0);
      checkOutput("reset sel_active_o", 32'(sel_active_o), 32'd0);

      applyStimulus(1'b0, 6'b00_00_00, {8'd4, 8'd1, 8'd0});
      repeat (2) step();
      countPulses(K_EN, 0, 20, n);
      checkOutput("ch0 max0 pulses in 20", n, 20);
      countPulses(K_EN, 1, 20, n);
      checkOutput("ch1 max1 pulses in 20", n, 10);
      countPulses(K_EN, 2, 20, n);
      checkOutput("ch2 max4 pulses in 20", n, 4);
      countPulses(K_TOG, 2, 20, n);
      checkOutput("ch2 toggle flips in 20", n, 4);
      measurePeriod(K_EN, 2, 20, p);
      checkOutput("ch2 max4 period", p, 5);

      // Chain channel 1 behind channel 0: ratio 4 * 2.
      applyStimulus(1'b0, 6'b00_10_00, {8'd4, 8'd1, 8'd3});
      nsw = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (sel_switched_o[1] === 1'b1) begin
            nsw++;
            checkOutput("ch1 switch on wrap", 32'(ch_en_o[1]), 32'd1);
         end
      end
      checkOutput("ch1 switch pulse count", nsw, 1);
      measurePeriod(K_EN, 1, 30, p);
      checkOutput("ch1 chained period", p, 8);

      // Channel 2 ratio 10, then request div-2 right after a wrap.
      applyStimulus(1'b0, 6'b00_10_00, {8'd9, 8'd1, 8'd3});
      gapToPulse(K_EN, 2, 20, p);
      gapToPulse(K_EN, 2, 20, p);
      checkOutput("ch2 max9 period", p, 10);
      applyStimulus(1'b0, 6'b01_10_00, {8'd9, 8'd1, 8'd3});
      gapToPulse(K_SW, 2, 30, p);
      checkOutput("ch2 switch waits for wrap", p, 10);
      checkOutput("ch2 switch on wrap", 32'(ch_en_o[2]), 32'd1);
      measurePeriod(K_EN, 2, 60, p);
      checkOutput("ch2 div2 period", p, 20);

      // A 3-cycle glitch on channel 0's switch must be filtered out.
      applyStimulus(1'b0, 6'b01_10_01, {8'd9, 8'd1, 8'd3});
      nsw = 0;
      for (int c = 0; c < 23; c++) begin
         step();
         if (c == 2) applyStimulus(1'b0, 6'b01_10_00, {8'd9, 8'd1, 8'd3});
         if (sel_switched_o !== 3'b000) nsw++;
      end
      checkOutput("glitch switch pulses", nsw, 0);
      checkOutput("glitch sel_active_o", 32'(sel_active_o), 32'h18);

      // Hold channel 0 for 20 cycles, then release it.
      applyStimulus(1'b0, 6'b01_10_11, {8'd9, 8'd1, 8'd3});
      gapToPulse(K_SW, 0, 30, p);
      checkOutput("ch0 hold applied", 32'(p > 0), 32'd1);
      tog0 = ch_toggle_o[0];
      countPulses(K_EN, 0, 20, n);
      checkOutput("ch0 hold enables", n, 0);
      checkOutput("ch0 hold toggle frozen", 32'(ch_toggle_o[0]), 32'(tog0));
      applyStimulus(1'b0, 6'b01_10_00, {8'd9, 8'd1, 8'd3});
      gapToPulse(K_SW, 0, 20, p);
      checkOutput("ch0 release latency", p, 7);
      gapToPulse(K_EN, 0, 20, p);
      checkOutput("ch0 resume first wrap", p, 4);

      // Reset in the middle of a long count.
      applyStimulus(1'b0, 6'b01_10_00, {8'd200, 8'd200, 8'd200});
      repeat (50) step();
      applyStimulus(1'b1, 6'b01_10_00, {8'd200, 8'd200, 8'd200});
      step();
      checkOutput("midreset ch_en_o", 32'(ch_en_o), 32'd0);
      checkOutput("midreset ch_toggle_o", 32'(ch_toggle_o), 32'd0);
      checkOutput("midreset sel_switched_o", 32'(sel_switched_o), 32'd0);
      checkOutput("midreset sel_active_o", 32'(sel_active_o), 32'd0);
      applyStimulus(1'b0, 6'b01_10_00, {8'd200, 8'd200, 8'd200});
      gapToPulse(K_EN, 0, 300, p);
      checkOutput("ch0 restart from zero", p, 201);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
